// File: rtl/acorn_pkg.sv
// ---------------------------------------------------------------------------
// acorn_pkg
// Shared constants for the ACORN-128 finalization / tag path.
//   ACORN_TAG_BITS    : authentication tag length in bits
//   ACORN_FINAL_STEPS : keystream steps consumed during finalization
//   VST_*             : encoding of the tag-verify controller states
// ---------------------------------------------------------------------------
package acorn_pkg;

  localparam int ACORN_TAG_BITS    = 128;
  localparam int ACORN_FINAL_STEPS = 768;

  localparam logic [1:0] VST_IDLE = 2'd0;
  localparam logic [1:0] VST_RUN  = 2'd1;
  localparam logic [1:0] VST_FIN  = 2'd2;

endpackage

// File: rtl/acorn_tag_verify.sv
// ---------------------------------------------------------------------------
// acorn_tag_verify
// Decrypt-side tag check for ACORN-128. Counts the bit-serial finalization
// keystream, captures the last TAG_BITS bits as the computed tag and ORs
// every bit difference against the received tag into a sticky flag. The
// verdict always takes exactly FINAL_STEPS accepted steps, wherever (or
// whether) a mismatch occurs.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : one-cycle pulse in IDLE; samples tag_exp
//   tag_exp      : received tag, bit i checked against keystream step
//                  FINAL_STEPS-TAG_BITS+i
//   abort        : cancels a running operation (no done, outputs cleared)
//   ks_valid     : one finalization step is presented this cycle
//   ks_bit       : keystream bit of that step
//   busy         : operation in progress (RUN or FIN)
//   done         : one-cycle verdict strobe
//   tag_ok       : 1 = tags match; qualified by done, held until next start
//   tag_calc     : captured computed tag
// ---------------------------------------------------------------------------
module acorn_tag_verify
  import acorn_pkg::*;
#(
  parameter int TAG_BITS    = ACORN_TAG_BITS,
  parameter int FINAL_STEPS = ACORN_FINAL_STEPS,
  parameter int CNT_W       = $clog2(FINAL_STEPS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TAG_BITS-1:0] tag_exp,
  input  logic                abort,
  input  logic                ks_valid,
  input  logic                ks_bit,
  output logic                busy,
  output logic                done,
  output logic                tag_ok,
  output logic [TAG_BITS-1:0] tag_calc
);

  // First step whose keystream bit belongs to the tag.
  localparam int CMP_BASE = FINAL_STEPS - TAG_BITS;

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_diff;
  logic                r_tag_ok;
  logic [TAG_BITS-1:0] r_tag_exp;
  logic [TAG_BITS-1:0] r_tag_calc;

  logic                w_accept;
  logic                w_last;
  logic [TAG_BITS-1:0] w_hit;
  logic [TAG_BITS-1:0] w_tag_calc_next;
  logic                w_mis;
  logic                w_diff_next;

  assign w_accept = (r_state == VST_RUN) && ks_valid;
  assign w_last   = w_accept && (r_cnt == CNT_W'(FINAL_STEPS - 1));

  // One-hot decode of the tag bit addressed by the current step. All of
  // w_hit is zero during the counted-only prefix, so the same datapath
  // runs every step and timing never depends on data.
  for (genvar gi = 0; gi < TAG_BITS; gi++) begin : g_slice
    assign w_hit[gi]           = w_accept && (r_cnt == CNT_W'(CMP_BASE + gi));
    assign w_tag_calc_next[gi] = w_hit[gi] ? ks_bit : r_tag_calc[gi];
  end

  assign w_mis       = |(w_hit & (r_tag_exp ^ {TAG_BITS{ks_bit}}));
  assign w_diff_next = r_diff | w_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= VST_IDLE;
      r_cnt      <= '0;
      r_diff     <= 1'b0;
      r_tag_ok   <= 1'b0;
      r_tag_exp  <= '0;
      r_tag_calc <= '0;
    end else begin
      case (r_state)
        VST_IDLE: begin
          if (start && !abort) begin
            r_state    <= VST_RUN;
            r_tag_exp  <= tag_exp;
            r_cnt      <= '0;
            r_diff     <= 1'b0;
            r_tag_calc <= '0;
            r_tag_ok   <= 1'b0;
          end
        end
        VST_RUN: begin
          if (abort) begin
            r_state    <= VST_IDLE;
            r_tag_ok   <= 1'b0;
            r_tag_calc <= '0;
          end else if (w_accept) begin
            r_cnt      <= r_cnt + CNT_W'(1);
            r_diff     <= w_diff_next;
            r_tag_calc <= w_tag_calc_next;
            if (w_last) begin
              r_state  <= VST_FIN;
              // Verdict registered on entry so it is valid alongside done.
              r_tag_ok <= ~w_diff_next;
            end
          end
        end
        VST_FIN: begin
          r_state <= VST_IDLE;
          if (abort) begin
            r_tag_ok   <= 1'b0;
            r_tag_calc <= '0;
          end
        end
        default: r_state <= VST_IDLE;
      endcase
    end
  end

  assign busy     = (r_state != VST_IDLE);
  // An abort landing on the FIN cycle suppresses the strobe.
  assign done     = (r_state == VST_FIN) && !abort;
  assign tag_ok   = r_tag_ok;
  assign tag_calc = r_tag_calc;

endmodule

// File: tb/tb_acorn_tag_verify.sv
// ---------------------------------------------------------------------------
// tb_acorn_tag_verify
// Randomized bench for acorn_tag_verify with an operation-level reference
// model (accepted-step count, captured tag array, whole-tag equality) and a
// per-cycle compare process, plus literal expectations for each scenario.
// ---------------------------------------------------------------------------
module tb_acorn_tag_verify;

  localparam int TB = 128;
  localparam int FS = 768;
  localparam int BASE = FS - TB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [TB-1:0] tag_exp = '0;
  logic          abort = 1'b0;
  logic          ks_valid = 1'b0;
  logic          ks_bit = 1'b0;
  logic          busy;
  logic          done;
  logic          tag_ok;
  logic [TB-1:0] tag_calc;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  acorn_tag_verify dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tag_exp  (tag_exp),
    .abort    (abort),
    .ks_valid (ks_valid),
    .ks_bit   (ks_bit),
    .busy     (busy),
    .done     (done),
    .tag_ok   (tag_ok),
    .tag_calc (tag_calc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [TB-1:0] act, input logic [TB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (operation level) ----------------
  bit            m_active = 1'b0;  // operation in progress
  bit            m_fin = 1'b0;     // verdict cycle pending
  int            m_n = 0;          // accepted finalization steps
  logic [TB-1:0] m_exp = '0;
  logic [TB-1:0] m_calc = '0;
  logic          m_ok = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_fin    <= 1'b0;
      m_calc   <= '0;
      m_ok     <= 1'b0;
    end else if (m_fin) begin
      m_fin    <= 1'b0;
      m_active <= 1'b0;
      if (abort) begin
        m_ok   <= 1'b0;
        m_calc <= '0;
      end
    end else if (m_active) begin
      if (abort) begin
        m_active <= 1'b0;
        m_ok     <= 1'b0;
        m_calc   <= '0;
      end else if (ks_valid) begin
        if (m_n >= BASE) m_calc[m_n-BASE] <= ks_bit;
        m_n <= m_n + 1;
        if (m_n == FS - 1) begin
          m_fin <= 1'b1;
          m_ok  <= ({ks_bit, m_calc[TB-2:0]} == m_exp);
        end
      end
    end else if (start && !abort) begin
      m_active <= 1'b1;
      m_n      <= 0;
      m_exp    <= tag_exp;
      m_calc   <= '0;
      m_ok     <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", busy, m_active);
      chk("cyc_done", done, m_fin && !abort);
      chk("cyc_tag_ok", tag_ok, m_ok);
      chk("cyc_tag_calc", tag_calc, m_calc);
    end
  end

  // ---------------- stimulus ----------------
  // Runs one verification. Steps >= BASE carry texp bits (step 'flip'
  // inverted); earlier steps are random when rnd is set, else zero.
  task automatic do_op(input logic [TB-1:0] texp, input bit rnd, input int flip,
                       input int per, input int abort_at, input int start_at,
                       input int rst_at, output bit got_done, output int lat,
                       output int last_v, output logic ok_o, output logic [TB-1:0] calc_o);
    int s;
    int c;
    bit stop;
    s = 0; got_done = 1'b0; lat = 0; last_v = 0; ok_o = 1'b0; calc_o = '0; stop = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; tag_exp = texp; ks_valid = 1'b1; ks_bit = 1'b1;  // same-cycle ks must be ignored
    @(posedge clk); #1;
    c = 1;
    while (!stop && c < 6000) begin
      start = 1'b0; abort = 1'b0; ks_valid = 1'b0; ks_bit = 1'b0;
      if (abort_at >= 0 && s == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_tag_ok", tag_ok, 0);
        chk("abort_tag_calc", tag_calc, 0);
        repeat (20) @(posedge clk);
        #1;
        stop = 1'b1;
      end else if (rst_at >= 0 && s == rst_at) begin
        #3 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tag_ok", tag_ok, 0);
        chk("rst_tag_calc", tag_calc, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        stop = 1'b1;
      end else begin
        if (s < FS && (c % per) == 0) begin
          ks_valid = 1'b1;
          if (s >= BASE) ks_bit = texp[s-BASE] ^ (s == flip);
          else ks_bit = rnd ? 1'($urandom % 2) : 1'b0;
          last_v = c;
          s++;
        end
        if (start_at >= 0 && s == start_at) begin
          start = 1'b1;
          tag_exp = ~texp;
        end
        @(negedge clk);
        if (done) begin
          got_done = 1'b1; lat = c; ok_o = tag_ok; calc_o = tag_calc; stop = 1'b1;
        end
        @(posedge clk); #1;
        c++;
      end
    end
    start = 1'b0; ks_valid = 1'b0; ks_bit = 1'b0; abort = 1'b0;
    $display("op tag=%h flip=%0d per=%0d abort_at=%0d rst_at=%0d done=%0d lat=%0d ok=%0d",
             texp, flip, per, abort_at, rst_at, got_done, lat, ok_o);
  endtask

  logic [TB-1:0] K;
  logic [TB-1:0] R;
  bit            gd;
  int            lat;
  int            lv;
  logic          ok;
  logic [TB-1:0] calc;
  int            fl;
  int            pr;

  initial begin
    K = 128'h0123456789ABCDEF0123456789ABCDEF;
    #2 rst = 1'b1;
    #20;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_tag_ok", tag_ok, 0);
    chk("reset_tag_calc", tag_calc, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cmp_en = 1'b1;

    // 1: all-zero tag and keystream
    do_op('0, 1'b0, -1, 1, -1, -1, -1, gd, lat, lv, ok, calc);
    chk("t1_done", gd, 1);
    chk("t1_lat", lat, 769);
    chk("t1_ok", ok, 1);
    chk("t1_calc", calc, 0);
    @(negedge clk);
    chk("t1_busy_after", busy, 0);

    // 2: matching tag, random prefix
    do_op(K, 1'b1, -1, 1, -1, -1, -1, gd, lat, lv, ok, calc);
    chk("t2_ok", ok, 1);
    chk("t2_calc", calc, K);
    chk("t2_lat", lat, 769);

    // 3: single flipped bit at the last step and at the first tag step
    do_op(K, 1'b1, 767, 1, -1, -1, -1, gd, lat, lv, ok, calc);
    chk("t3a_ok", ok, 0);
    chk("t3a_calc", calc, 128'h8123456789ABCDEF0123456789ABCDEF);
    chk("t3a_lat", lat, 769);
    do_op(K, 1'b1, 640, 1, -1, -1, -1, gd, lat, lv, ok, calc);
    chk("t3b_ok", ok, 0);
    chk("t3b_calc", calc, 128'h0123456789ABCDEF0123456789ABCDEE);
    chk("t3b_lat", lat, 769);

    // 4: sparse valids with a stray start mid-stream
    do_op(K, 1'b1, -1, 3, -1, 300, -1, gd, lat, lv, ok, calc);
    chk("t4_ok", ok, 1);
    chk("t4_calc", calc, K);
    chk("t4_lat", lat, 2305);
    chk("t4_lat_after_last", lat, lv + 1);

    // 5: abort, then a clean run
    do_op(K, 1'b1, -1, 1, 700, -1, -1, gd, lat, lv, ok, calc);
    chk("t5_no_done", gd, 0);
    do_op(K, 1'b1, -1, 1, -1, -1, -1, gd, lat, lv, ok, calc);
    chk("t5_ok", ok, 1);

    // 6: async reset mid-run, idle ks pulses, then a clean run
    do_op(K, 1'b1, -1, 1, -1, -1, 650, gd, lat, lv, ok, calc);
    chk("t6_no_done", gd, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      ks_valid = 1'b1; ks_bit = 1'($urandom % 2);
    end
    @(posedge clk); #1;
    ks_valid = 1'b0;
    R = {$urandom, $urandom, $urandom, $urandom};
    do_op(R, 1'b1, -1, 1, -1, -1, -1, gd, lat, lv, ok, calc);
    chk("t6_ok", ok, 1);
    chk("t6_calc", calc, R);

    // Randomized runs: flips before the tag window must not matter
    for (int i = 0; i < 4; i++) begin
      R  = {$urandom, $urandom, $urandom, $urandom};
      fl = ($urandom % 2) ? -1 : int'($urandom % 768);
      pr = 1 + int'($urandom % 2);
      do_op(R, 1'b1, fl, pr, -1, -1, -1, gd, lat, lv, ok, calc);
      chk("rnd_done", gd, 1);
      chk("rnd_ok", ok, (fl < BASE) ? 1 : 0);
      chk("rnd_calc", calc, (fl >= BASE) ? (R ^ (128'd1 << (fl - BASE))) : R);
      chk("rnd_lat", lat, lv + 1);
    end

    repeat (3) @(posedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acorn_tag_verify.md
Name: acorn_tag_verify

Overview:
Decryption-side counterpart of the ACORN-128 finalization/tag generator. It consumes the bit-serial keystream produced during the 768 finalization steps, captures the last 128 keystream bits as the computed tag, and compares them against the received (expected) tag. The comparison is constant-time: there is no early exit on mismatch. It sits after the state-update/KSG datapath in the decrypt path and drives the authentication pass/fail flag to the host interface.

Parameters:
TAG_BITS, 128, tag length in bits
FINAL_STEPS, 768, number of finalization keystream steps consumed per operation
CNT_W, $clog2(FINAL_STEPS+1), step counter width (10 at defaults)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse; begins a verification; samples tag_exp
tag_exp  input  TAG_BITS  received tag; bit i is compared first-to-last for i=0..TAG_BITS-1
abort  input  1  cancels an operation in progress
ks_valid  input  1  ks_bit is valid this cycle (one finalization step)
ks_bit  input  1  keystream bit of the current finalization step
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when the verdict is valid
tag_ok  output  1  1 = tags match; valid from done until the next start
tag_calc  output  TAG_BITS  captured computed tag; bit i = keystream at step FINAL_STEPS-TAG_BITS+i

Behaviour:
- Reset (asynchronous): state=IDLE; busy=0, done=0, tag_ok=0, tag_calc=0; step counter=0; diff accumulator=0; tag register=0.
- FSM states:
  - IDLE: on start, latch tag_exp, clear step counter, diff_acc and tag_calc, clear tag_ok, and go to RUN.
  - RUN: busy=1.
  - FIN: one cycle; done=1; tag_ok=~diff_acc; return to IDLE.
- RUN, per cycle with ks_valid=1:
  - step = current counter value (0-based).
  - If step >= FINAL_STEPS-TAG_BITS: j = step-(FINAL_STEPS-TAG_BITS); tag_calc[j] <= ks_bit; diff_acc <= diff_acc | (ks_bit ^ tag_r[j]).
  - Steps below FINAL_STEPS-TAG_BITS are counted only; their bits are not compared.
  - Counter increments. The step with index FINAL_STEPS-1 moves the FSM to FIN.
  - Latency: done rises on the cycle after the 768th accepted ks_valid.
- ks_valid=0 in RUN: hold all state. Gaps of any length are allowed.
- Constant time: the mismatch position never changes the cycle count, the counter, or the timing of done.
- Boundaries:
  - start while busy (RUN/FIN): ignored.
  - ks_valid in IDLE or FIN: ignored.
  - start and ks_valid in the same IDLE cycle: the ks bit is ignored; counting begins on the next cycle.
  - abort in RUN or FIN: next state IDLE; no done pulse; tag_ok=0; tag_calc is cleared. abort in IDLE has no effect. abort and start in the same cycle: abort wins; no operation starts.
  - Reset mid-operation: the operation is discarded and all outputs take their reset values.
  - The counter never wraps. It is bounded by the transition to FIN.
- tag_ok is only meaningful when qualified by done. It stays 0 throughout RUN so that a partial result never reads as a pass.

Decomposition:
- Shared package acorn_pkg holds:
  - ACORN_TAG_BITS=128
  - ACORN_FINAL_STEPS=768
  - the verify FSM state encoding (IDLE, RUN, FIN), 2 bits
- No sub-module is required. The bit-serial compare/capture slice (index decode, tag_calc write, diff OR) is inline logic in this module.

Test Plan:
1. tag_exp=0; start; 768 consecutive ks_valid with ks_bit=0 -> done exactly 769 cycles after start, tag_ok=1, tag_calc=0, busy low after done.
2. tag_exp=128'h0123...CDEF; the last 128 ks_bits are driven equal to tag_exp bits 0..127 and the first 640 bits are random -> tag_ok=1 and tag_calc=tag_exp.
3. Same as 2 but step 767 has ks_bit flipped -> tag_ok=0 and tag_calc[127] differs. Also flip step 640 only -> tag_ok=0. In both cases done arrives on the same cycle as in the matching run.
4. Matching tag with ks_valid asserted every third cycle -> tag_ok=1; done on the cycle after the 768th valid. A start pulse injected at step 300 is ignored, and the result is unchanged.
5. abort at step 700 -> no done pulse, busy=0 next cycle, tag_ok=0, tag_calc=0. A new start followed by a full matching stream then gives tag_ok=1.
6. rst asserted asynchronously at step 650 -> all outputs zero immediately. ks_valid pulses while in IDLE have no effect; a subsequent full run completes normally.
